osd_debug_probe_sampler: RTL and testbench

- Upstream feeder for the OSD hex overlay.
- Selects one of NUM_CH 8-bit debug probes from the core and latches it once per frame at the leading edge of VS. The overlay's two hex digits therefore never change mid-frame.
- Supports automatic channel rotation, manual channel step via a button, and a freeze input. It outputs the held byte plus the channel index for display.

---
 rtl/osd_debug_probe_sampler.sv | 80 ++++++++
 tb/tb_osd_debug_probe_sampler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/osd_debug_probe_sampler.sv
// Per-frame debug probe sampler for the OSD hex overlay. It latches one 8-bit
// probe channel at each VS leading edge and supports auto-rotate, manual step and freeze.
module osd_debug_probe_sampler #(
  parameter int NUM_CH       = 4,
  parameter int DWELL_FRAMES = 60,
  parameter int AUTO_CYCLE   = 1,
  parameter int VS_POL       = 1,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  VS,
  input  logic [8*NUM_CH-1:0]   probe_in,
  input  logic                  next_btn,
  input  logic                  freeze,
  output logic [7:0]            debug_value,
  output logic [CH_W-1:0]       debug_chan,
  output logic                  frame_strobe
);

  localparam int DW_W = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_FRAMES - 1);
  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);

  logic            vs_act, vs_act_d, frame_start;
  logic            btn_d, btn_rise, pending;
  logic [DW_W-1:0] dwell, dwell_next;
  logic [CH_W-1:0] next_chan;
  logic            adv;
  logic [7:0]      sel_value;

  assign vs_act      = (VS == 1'(VS_POL));
  assign frame_start = vs_act & ~vs_act_d;
  assign btn_rise    = next_btn & ~btn_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_chan  = debug_chan;
    dwell_next = dwell;
    adv        = pending | btn_rise | ((AUTO_CYCLE != 0) && (dwell == DWELL_LAST));
    if (adv) begin
      next_chan  = (debug_chan == CH_LAST) ? '0 : debug_chan + CH_W'(1);
      dwell_next = '0;
    end else if (dwell != DWELL_LAST) begin
      dwell_next = dwell + DW_W'(1);
    end
  end

  // Value is taken from the channel being switched to, so value and channel always agree.
  assign sel_value = probe_in[8*int'(next_chan) +: 8];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Edge detectors start at their active level, so an input already active at release is not an edge.
      vs_act_d     <= 1'b1;
      btn_d        <= 1'b1;
      pending      <= 1'b0;
      dwell        <= '0;
      debug_chan   <= '0;
      debug_value  <= '0;
      frame_strobe <= 1'b0;
    end else begin
      vs_act_d     <= vs_act;
      btn_d        <= next_btn;
      frame_strobe <= frame_start;
      if (freeze) begin
        pending <= 1'b0;
      end else if (frame_start) begin
        pending     <= 1'b0;
        debug_chan  <= next_chan;
        debug_value <= sel_value;
        dwell       <= dwell_next;
      end else if (btn_rise) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_osd_debug_probe_sampler.sv
// Bench for osd_debug_probe_sampler: a manual-step and an auto-rotate instance share
// stimulus; expected frame results are queued at each VS edge and popped on frame_strobe.
module tb_osd_debug_probe_sampler;

  logic        clk = 1'b0;
  logic        reset, VS, next_btn, freeze;
  logic [31:0] probe_in;
  logic [7:0]  value_m, value_a;
  logic [1:0]  chan_m, chan_a;
  logic        strobe_m, strobe_a;

  osd_debug_probe_sampler #(.NUM_CH(4), .DWELL_FRAMES(2), .AUTO_CYCLE(0), .VS_POL(1)) dut_m (
    .clk(clk), .reset(reset), .VS(VS), .probe_in(probe_in), .next_btn(next_btn),
    .freeze(freeze), .debug_value(value_m), .debug_chan(chan_m), .frame_strobe(strobe_m));

  osd_debug_probe_sampler #(.NUM_CH(4), .DWELL_FRAMES(2), .AUTO_CYCLE(1), .VS_POL(1)) dut_a (
    .clk(clk), .reset(reset), .VS(VS), .probe_in(probe_in), .next_btn(next_btn),
    .freeze(freeze), .debug_value(value_a), .debug_chan(chan_a), .frame_strobe(strobe_a));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] probes;
    int          n_btn;
    bit          frz;
    bit          btn_at_edge;
    bit          blip;
    logic [1:0]  chan_m;
    logic [7:0]  val_m;
    logic [1:0]  chan_a;
    logic [7:0]  val_a;
  } frame_t;

  typedef struct {
    logic [1:0] chan_m;
    logic [7:0] val_m;
    logic [1:0] chan_a;
    logic [7:0] val_a;
    int         cyc;
  } exp_t;

  localparam int N_FRAMES  = 21;
  localparam int RESET_IDX = 19;

  frame_t tbl [N_FRAMES];
  exp_t   sb [$];
  exp_t   hold;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (strobe_m || strobe_a) begin
        check("strobe_pair", {31'd0, strobe_m}, {31'd0, strobe_a});
        if (sb.size() == 0) begin
          check("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("strobe_latency", 32'(cyc - e.cyc), 32'd1);
          check("chan_m", {30'd0, chan_m}, {30'd0, e.chan_m});
          check("value_m", {24'd0, value_m}, {24'd0, e.val_m});
          check("chan_a", {30'd0, chan_a}, {30'd0, e.chan_a});
          check("value_a", {24'd0, value_a}, {24'd0, e.val_a});
          hold = e;
        end
      end else begin
        check("hold_m", {22'd0, chan_m, value_m}, {22'd0, hold.chan_m, hold.val_m});
        check("hold_a", {22'd0, chan_a, value_a}, {22'd0, hold.chan_a, hold.val_a});
      end
    end
  end

  task automatic do_frame(input frame_t f);
    exp_t e;
    @(negedge clk);
    probe_in = f.probes;
    freeze   = f.frz;
    VS       = 1'b0;
    next_btn = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < f.n_btn; i++) begin
      @(negedge clk) next_btn = 1'b1;
      @(negedge clk) next_btn = 1'b0;
    end
    if (f.blip) begin
      @(negedge clk) freeze = 1'b1;
      @(negedge clk) freeze = f.frz;
    end
    @(negedge clk);
    @(negedge clk);
    VS       = 1'b1;
    next_btn = f.btn_at_edge;
    e = '{chan_m: f.chan_m, val_m: f.val_m, chan_a: f.chan_a, val_a: f.val_a, cyc: cyc};
    sb.push_back(e);
    @(negedge clk) next_btn = 1'b0;
    repeat (3) @(negedge clk);
    check("strobe_arrived", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            probes        btn frz edg blp  chm  valm   cha  vala
    tbl[0]  = '{32'h44332211, 0, 0, 0, 0, 2'd0, 8'h11, 2'd0, 8'h11};
    tbl[1]  = '{32'h443322AA, 0, 0, 0, 0, 2'd0, 8'hAA, 2'd1, 8'h22};
    tbl[2]  = '{32'h44332211, 0, 0, 0, 0, 2'd0, 8'h11, 2'd1, 8'h22};
    tbl[3]  = '{32'h44332211, 0, 0, 0, 0, 2'd0, 8'h11, 2'd2, 8'h33};
    tbl[4]  = '{32'h44332211, 0, 0, 0, 0, 2'd0, 8'h11, 2'd2, 8'h33};
    tbl[5]  = '{32'h44332211, 0, 0, 0, 0, 2'd0, 8'h11, 2'd3, 8'h44};
    tbl[6]  = '{32'h44332211, 0, 0, 0, 0, 2'd0, 8'h11, 2'd3, 8'h44};
    tbl[7]  = '{32'h44332211, 0, 0, 0, 0, 2'd0, 8'h11, 2'd0, 8'h11};
    tbl[8]  = '{32'h44332211, 0, 0, 0, 0, 2'd0, 8'h11, 2'd0, 8'h11};
    tbl[9]  = '{32'h44332211, 3, 0, 0, 0, 2'd1, 8'h22, 2'd1, 8'h22};
    tbl[10] = '{32'h44332211, 0, 0, 0, 0, 2'd1, 8'h22, 2'd1, 8'h22};
    tbl[11] = '{32'h44332211, 0, 0, 1, 0, 2'd2, 8'h33, 2'd2, 8'h33};
    tbl[12] = '{32'h5A6B7C8D, 2, 1, 0, 0, 2'd2, 8'h33, 2'd2, 8'h33};
    tbl[13] = '{32'h01020304, 1, 1, 0, 0, 2'd2, 8'h33, 2'd2, 8'h33};
    tbl[14] = '{32'h5A6B7C8D, 3, 1, 0, 0, 2'd2, 8'h33, 2'd2, 8'h33};
    tbl[15] = '{32'hFFEEDDCC, 2, 1, 0, 0, 2'd2, 8'h33, 2'd2, 8'h33};
    tbl[16] = '{32'h44332211, 0, 0, 0, 0, 2'd2, 8'h33, 2'd2, 8'h33};
    tbl[17] = '{32'h44332211, 0, 0, 0, 0, 2'd2, 8'h33, 2'd3, 8'h44};
    tbl[18] = '{32'h5A6B7C8D, 1, 0, 0, 0, 2'd3, 8'h5A, 2'd0, 8'h8D};
    tbl[19] = '{32'h44332211, 0, 0, 0, 0, 2'd0, 8'h11, 2'd0, 8'h11};
    tbl[20] = '{32'h44332211, 1, 0, 0, 1, 2'd0, 8'h11, 2'd1, 8'h22};

    hold = '{chan_m: 2'd0, val_m: 8'h00, chan_a: 2'd0, val_a: 8'h00, cyc: 0};

    // Reset released while VS and next_btn are already active: no event may follow.
    reset    = 1'b1;
    VS       = 1'b1;
    next_btn = 1'b1;
    freeze   = 1'b0;
    probe_in = 32'h44332211;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_strobe_after_reset", {30'd0, strobe_m, strobe_a}, 32'd0);
    end
    check("reset_value_m", {22'd0, chan_m, value_m}, 32'd0);
    check("reset_value_a", {22'd0, chan_a, value_a}, 32'd0);

    for (int i = 0; i < RESET_IDX; i++) do_frame(tbl[i]);

    // Reset while VS is held active mid-frame; no update until a fresh VS edge.
    @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check("midreset_m", {21'd0, strobe_m, chan_m, value_m}, 32'd0);
    check("midreset_a", {21'd0, strobe_a, chan_a, value_a}, 32'd0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("no_strobe_after_midreset", {30'd0, strobe_m, strobe_a}, 32'd0);
    end
    hold   = '{chan_m: 2'd0, val_m: 8'h00, chan_a: 2'd0, val_a: 8'h00, cyc: 0};
    mon_en = 1'b1;

    for (int i = RESET_IDX; i < N_FRAMES; i++) do_frame(tbl[i]);

    repeat (5) @(negedge clk);
    check("queue_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
